imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate generator, sitting in the decode stage between the instruction register and the ID/EX boundary.
- Extracts and sign-extends I/S/B/U/J immediates to XLEN bits and adds a CSR zero-extended immediate mode (Z).
- Flags illegal selects.
- Carries a sideband tag through a one-cycle, valid/ready-handshaked output register backed by a one-entry skid buffer, so back-pressure does not combinationally reach upstream.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
TAG_W, 4, width of the opaque sideband tag (e.g. ROB or PC index) passed through unchanged.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  discards all buffered entries this cycle.
in_valid  input  1  upstream offers an instruction.
in_ready  output  1  block can accept this cycle.
in_instr  input  25  instruction bits [31:7].
in_imm_sel  input  3  immediate format select.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  out_imm/out_tag/out_illegal are valid.
out_ready  input  1  downstream consumes this cycle.
out_imm  output  XLEN  extended immediate.
out_tag  output  TAG_W  tag of the entry on the output.
out_illegal  output  1  in_imm_sel was not a defined encoding.

Behaviour:
- Select encodings: IMM_I=3'd0, IMM_S=3'd1, IMM_B=3'd2, IMM_U=3'd3, IMM_J=3'd4, IMM_Z=3'd5.
- Encodings 3'd6 and 3'd7 are illegal: imm=0, illegal=1.
- Bit fields, expressed in full-instruction bit numbering:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: sext({instr[31:12], 12'b0}); for XLEN=64, bit 31 is replicated into bits 63:32.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Z: zero-extended instr[19:15].
- Extension is computed combinationally on the input side; only the result is registered.
- State: output register O (valid bit plus data) and skid register K (valid bit plus data).
- in_ready = !K.valid, driven directly from the flop with no combinational path from out_ready.
- Accept occurs when in_valid && in_ready. Out-consume occurs when out_valid && out_ready.
- O may load when it is empty or is being consumed. When O may load:
  - If K is valid, O takes K's entry and K is cleared.
  - Else if an accept occurs, O takes the new entry.
  - Else O clears.
- When O may not load and an accept occurs, the entry goes to K.
- Latency is 1 cycle from accept to out_valid when the pipeline is empty. Order is strictly FIFO. Peak throughput is 1 entry/cycle.
- Outputs are held stable while out_valid && !out_ready.
- flush: at the next edge both valid bits clear; any accept in the same cycle is dropped; an out-consume in the same cycle still counts downstream.
- Reset: O.valid=0, K.valid=0, out_imm=0, out_tag=0, out_illegal=0. in_ready reads 1 during and after reset. Any handshake during reset is ignored.
- Reset dominates flush. Reset asserted mid-stream drops all entries.
- An XLEN value other than 32 or 64 is rejected at elaboration.

Decomposition:
- Package imm_gen_pkg holds:
  - the imm_sel_e enum with the six encodings above;
  - the IMM_SEL_W=3 constant;
  - a packed entry struct {imm, tag, illegal} parametrised through localparams in the module.
- One natural combinational sub-module, imm_expand #(XLEN): takes instr[31:7] and imm_sel, and returns imm and illegal.
- Handshake, skid and flush logic live in imm_gen_pipe.

Test Plan:
- XLEN=32, send 0xFFF00093 (ADDI x1,x0,-1) with IMM_I and tag 3 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_tag=3. Repeat with XLEN=64 -> out_imm=0xFFFFFFFFFFFFFFFF.
- Format sweep:
  - 0x00102123 with IMM_S -> 0x00000002.
  - 0xFE000EE3 with IMM_B -> 0xFFFFFFFC.
  - 0x80000097 with IMM_U, XLEN=64 -> 0xFFFFFFFF80000000.
  - 0x008000EF with IMM_J -> 0x00000008.
  - 0x0052D0F3 with IMM_Z -> 0x00000005.
- Back-pressure: hold out_ready=0 and offer tags 1, 2, 3 on consecutive cycles.
  - Tag 1 sits in O and tag 2 in K; in_ready=0 from the cycle after tag 2 is accepted; tag 3 is held upstream.
  - Raise out_ready -> tags 1, 2, 3 appear in order on consecutive cycles with no duplicates or losses.
- Illegal select 3'd7 on 0x00100093 -> out_illegal=1, out_imm=0. The following legal entry has out_illegal=0.
- Flush with O and K full and in_valid=1 -> next cycle out_valid=0, in_ready=1. The offered entry never appears.
- Assert rst for 1 cycle while out_valid=1 and out_ready=0 -> after reset out_valid=0, out_imm=0, in_ready=1. A fresh entry then has latency 1.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined immediate generator.
// Select encodings and the legality helper used by the expander.
package imm_gen_pkg;

  localparam int IMM_SEL_W = 3;
  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [IMM_SEL_W-1:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_Z = 3'd5
  } imm_sel_e;

  function automatic logic sel_legal(
    input logic [IMM_SEL_W-1:0] sel
  );
    return (sel <= IMM_Z);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus between the instruction register and ID/EX.
// Input offer, output result and flush share one bundle.
interface imm_gen_pipe_if
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [24:0]          in_instr;
  logic [IMM_SEL_W-1:0] in_imm_sel;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_imm;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_illegal;

  modport master (
    output flush,
    output in_valid,
    input  in_ready,
    output in_instr,
    output in_imm_sel,
    output in_tag,
    input  out_valid,
    output out_ready,
    input  out_imm,
    input  out_tag,
    input  out_illegal
  );

  modport slave (
    input  flush,
    input  in_valid,
    output in_ready,
    input  in_instr,
    input  in_imm_sel,
    input  in_tag,
    output out_valid,
    input  out_ready,
    output out_imm,
    output out_tag,
    output out_illegal
  );

endinterface

// File: rtl/imm_expand.sv
// Combinational immediate extraction and extension.
// Every format is built as a 32-bit signed value, then widened.
module imm_expand
  import imm_gen_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:7]          instr,
  input  logic [IMM_SEL_W-1:0] sel,
  output logic [XLEN-1:0]      imm,
  output logic                 illegal
);

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    unique case (1'b1)
      (sel == IMM_I):
        raw = {{20{instr[31]}}, instr[31:20]};
      (sel == IMM_S):
        raw = {{20{instr[31]}},
               instr[31:25], instr[11:7]};
      (sel == IMM_B):
        raw = {{19{instr[31]}}, instr[31],
               instr[7], instr[30:25],
               instr[11:8], 1'b0};
      (sel == IMM_U):
        raw = {instr[31:12], 12'b0};
      (sel == IMM_J):
        raw = {{11{instr[31]}}, instr[31],
               instr[19:12], instr[20],
               instr[30:21], 1'b0};
      (sel == IMM_Z):
        raw = {27'b0, instr[19:15]};
      default:
        raw = '0;
    endcase
  end

  // Z has bit 31 clear, so sign extension is also zero extension
  assign imm     = XLEN'($signed(raw));
  assign illegal = !sel_legal(sel);

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with a registered output
// and a one-entry skid buffer; in_ready comes straight off a flop.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input logic           clk,
  input logic           rst,
  imm_gen_pipe_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  logic [XLEN-1:0] new_imm;
  logic            new_ill;
  entry_t          new_e;

  entry_t o_q, o_d;
  entry_t k_q, k_d;
  logic   o_vld_q, o_vld_d;
  logic   k_vld_q, k_vld_d;
  logic   accept;
  logic   o_load;

  imm_expand #(
    .XLEN (XLEN)
  ) u_expand (
    .instr   (bus.in_instr),
    .sel     (bus.in_imm_sel),
    .imm     (new_imm),
    .illegal (new_ill)
  );

  assign new_e = '{
    imm:     new_imm,
    tag:     bus.in_tag,
    illegal: new_ill
  };

  assign accept = bus.in_valid && !k_vld_q;
  assign o_load = !o_vld_q || bus.out_ready;

  always_comb begin
    o_d     = o_q;
    o_vld_d = o_vld_q;
    k_d     = k_q;
    k_vld_d = k_vld_q;
    if (o_load) begin
      if (k_vld_q) begin
        o_d     = k_q;
        o_vld_d = 1'b1;
        k_vld_d = 1'b0;
      end else if (accept) begin
        o_d     = new_e;
        o_vld_d = 1'b1;
      end else begin
        o_vld_d = 1'b0;
      end
    end else if (accept) begin
      k_d     = new_e;
      k_vld_d = 1'b1;
    end
    // flush wins over any load or accept this cycle
    if (bus.flush) begin
      o_vld_d = 1'b0;
      k_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q     <= '0;
      k_q     <= '0;
      o_vld_q <= 1'b0;
      k_vld_q <= 1'b0;
    end else begin
      o_q     <= o_d;
      k_q     <= k_d;
      o_vld_q <= o_vld_d;
      k_vld_q <= k_vld_d;
    end
  end

  assign bus.in_ready    = !k_vld_q;
  assign bus.out_valid   = o_vld_q;
  assign bus.out_imm     = o_q.imm;
  assign bus.out_tag     = o_q.tag;
  assign bus.out_illegal = o_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 copies driven in
// lockstep against a FIFO-level reference model.
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [3:0]  tag;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [2:0]  sel = 3'd0;
  logic [3:0]  tag = 4'd0;
  logic        out_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  ent_t mq[$];

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) i32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) i64 ();

  assign i32.flush      = flush;
  assign i32.in_valid   = in_valid;
  assign i32.in_instr   = instr[31:7];
  assign i32.in_imm_sel = sel;
  assign i32.in_tag     = tag;
  assign i32.out_ready  = out_ready;
  assign i64.flush      = flush;
  assign i64.in_valid   = in_valid;
  assign i64.in_instr   = instr[31:7];
  assign i64.in_imm_sel = sel;
  assign i64.in_tag     = tag;
  assign i64.out_ready  = out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (i32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (i64)
  );

  wire        v32   = i32.out_valid;
  wire        v64   = i64.out_valid;
  wire        rdy32 = i32.in_ready;
  wire        rdy64 = i64.in_ready;
  wire [31:0] imm32 = i32.out_imm;
  wire [63:0] imm64 = i64.out_imm;
  wire [3:0]  tag32 = i32.out_tag;
  wire [3:0]  tag64 = i64.out_tag;
  wire        ill32 = i32.out_illegal;
  wire        ill64 = i64.out_illegal;

  always #5 clk = ~clk;

  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    if (v[bits-1]) return v - (64'd1 << bits);
    return v;
  endfunction

  // Reference immediate, XLEN=64 view; the 32-bit result is its low half
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] s);
    logic [63:0] w, v;
    w = {32'h0, ins};
    case (s)
      3'd0: v = sx(w >> 20, 12);
      3'd1: v = sx((((w >> 25) & 64'h7f) << 5) + ((w >> 7) & 64'h1f), 12);
      3'd2: v = sx((((w >> 31) & 1) * 4096) + (((w >> 7) & 1) * 2048)
                   + (((w >> 25) & 63) * 32) + (((w >> 8) & 15) * 2), 13);
      3'd3: v = sx(w & 64'hffff_f000, 32);
      3'd4: v = sx((((w >> 31) & 1) << 20) + (((w >> 12) & 255) << 12)
                   + (((w >> 20) & 1) << 11) + (((w >> 21) & 1023) << 1), 21);
      3'd5: v = (w >> 15) & 31;
      default: v = 64'h0;
    endcase
    return v;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [2:0] s, input logic [3:0] t);
    in_valid = v;
    instr    = ins;
    sel      = s;
    tag      = t;
  endtask

  task automatic tick();
    bit acc, con;
    ent_t e;
    @(posedge clk);
    acc = in_valid && (mq.size() < 2);
    con = (mq.size() > 0) && out_ready;
    e.instr = instr;
    e.sel = sel;
    e.tag = tag;
    if (rst) mq.delete();
    else begin
      if (con) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (acc) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0, 4'd9);
    tick();
    tick();
    n_cmp++;
    if ({v32, rdy32, imm32, tag32, ill32} !== {1'b0, 1'b1, 32'h0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_x32 got v=%b rdy=%b imm=%h tag=%h ill=%b want 0 1 0 0 0",
               v32, rdy32, imm32, tag32, ill32);
    end
    n_cmp++;
    if ({v64, rdy64, imm64, tag64, ill64} !== {1'b0, 1'b1, 64'h0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_x64 got v=%b rdy=%b imm=%h tag=%h ill=%b want 0 1 0 0 0",
               v64, rdy64, imm64, tag64, ill64);
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    tick();
    n_cmp++;
    if ({v32, v64, rdy32, rdy64} !== 4'b0011) begin
      n_bad++;
      $display("FAIL reset_release got v=%b%b rdy=%b%b want 00 11", v32, v64, rdy32, rdy64);
    end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 3'd0, 4'd3);
    tick();
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    n_cmp++;
    if ({v32, imm32, tag32} !== {1'b1, 32'hFFFF_FFFF, 4'd3}) begin
      n_bad++;
      $display("FAIL addi_x32 got v=%b imm=%h tag=%0d want 1 ffffffff 3", v32, imm32, tag32);
    end
    n_cmp++;
    if ({v64, imm64, tag64} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3}) begin
      n_bad++;
      $display("FAIL addi_x64 got v=%b imm=%h tag=%0d want 1 ffffffffffffffff 3", v64, imm64, tag64);
    end
    tick();
    n_cmp++;
    if ({v32, v64} !== 2'b00) begin
      n_bad++;
      $display("FAIL addi_drain got v=%b%b want 00", v32, v64);
    end
  endtask

  task automatic test_formats();
    logic [31:0] ins[7];
    logic [2:0]  s[7];
    logic [63:0] e[7];
    logic        il[7];
    ins = '{32'h00102123, 32'hFE000EE3, 32'h80000097, 32'h008000EF,
            32'h0052D0F3, 32'h00100093, 32'h00100093};
    s   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0};
    e   = '{64'h2, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_8000_0000,
            64'h8, 64'h5, 64'h0, 64'h1};
    il  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ins[i], s[i], 4'(i));
      tick();
      n_cmp++;
      if ({v32, imm32, ill32, tag32} !== {1'b1, e[i][31:0], il[i], 4'(i)}) begin
        n_bad++;
        $display("FAIL fmt%0d_x32 got v=%b imm=%h ill=%b tag=%0d want 1 %h %b %0d",
                 i, v32, imm32, ill32, tag32, e[i][31:0], il[i], i);
      end
      n_cmp++;
      if ({v64, imm64, ill64, tag64} !== {1'b1, e[i], il[i], 4'(i)}) begin
        n_bad++;
        $display("FAIL fmt%0d_x64 got v=%b imm=%h ill=%b tag=%0d want 1 %h %b %0d",
                 i, v64, imm64, ill64, tag64, e[i], il[i], i);
      end
    end
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] want_tag[5];
    logic       want_rdy[5];
    want_tag = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3};
    want_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, 32'h00100093 + (32'(i) << 20), 3'd0, 4'(i + 1));
      if (i == 3) out_ready = 1'b1;
      tick();
      n_cmp++;
      if ({v32, tag32, rdy32, v64, tag64, rdy64} !==
          {1'b1, want_tag[i], want_rdy[i], 1'b1, want_tag[i], want_rdy[i]}) begin
        n_bad++;
        $display("FAIL bp_step%0d got v=%b%b tag=%0d/%0d rdy=%b%b want 11 %0d %b",
                 i, v32, v64, tag32, tag64, rdy32, rdy64, want_tag[i], want_rdy[i]);
      end
    end
    n_cmp++;
    if ({imm32, imm64} !== {32'h3, 64'h3}) begin
      n_bad++;
      $display("FAIL bp_tag3_imm got %h/%h want 3", imm32, imm64);
    end
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    tick();
    n_cmp++;
    if ({v32, v64} !== 2'b00) begin
      n_bad++;
      $display("FAIL bp_no_dup got v=%b%b tag=%0d want 00", v32, v64, tag32);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd0, 4'd4);
    tick();
    drive(1'b1, 32'h00200093, 3'd0, 4'd5);
    tick();
    drive(1'b1, 32'h00300093, 3'd0, 4'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    n_cmp++;
    if ({v32, rdy32, v64, rdy64} !== 4'b0101) begin
      n_bad++;
      $display("FAIL flush_full got v=%b%b rdy=%b%b want 00 11", v32, v64, rdy32, rdy64);
    end
    out_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({v32, v64} !== 2'b00) begin
      n_bad++;
      $display("FAIL flush_full_leak got v=%b%b tag=%0d want 00", v32, v64, tag32);
    end
    out_ready = 1'b0;
    drive(1'b1, 32'h00600093, 3'd0, 4'd6);
    tick();
    drive(1'b1, 32'h00A00093, 3'd0, 4'd10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({v32, v64, rdy32, rdy64} !== 4'b0011) begin
      n_bad++;
      $display("FAIL flush_accept_drop got v=%b%b tag=%0d want 00", v32, v64, tag32);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0, 4'd5);
    tick();
    n_cmp++;
    if ({v32, v64} !== 2'b11) begin
      n_bad++;
      $display("FAIL rstmid_pre got v=%b%b want 11", v32, v64);
    end
    rst = 1'b1;
    drive(1'b1, 32'h00700093, 3'd0, 4'd8);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    n_cmp++;
    if ({v32, rdy32, imm32, v64, rdy64, imm64} !== {2'b01, 32'h0, 2'b01, 64'h0}) begin
      n_bad++;
      $display("FAIL rstmid_post got v=%b%b rdy=%b%b imm=%h/%h want 00 11 0",
               v32, v64, rdy32, rdy64, imm32, imm64);
    end
    drive(1'b1, 32'h00500093, 3'd0, 4'd7);
    tick();
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    n_cmp++;
    if ({v32, imm32, tag32, v64, imm64, tag64} !== {1'b1, 32'h5, 4'd7, 1'b1, 64'h5, 4'd7}) begin
      n_bad++;
      $display("FAIL rstmid_fresh got v=%b%b imm=%h/%h tag=%0d want 11 5 7",
               v32, v64, imm32, imm64, tag32);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    ent_t h;
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      drive(($urandom_range(0, 9) < 7), $urandom, 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)));
      tick();
      n_cmp++;
      if ({rdy32, v32, rdy64, v64} !==
          {mq.size() < 2, mq.size() > 0, mq.size() < 2, mq.size() > 0}) begin
        n_bad++;
        $display("FAIL rnd_hs c=%0d got rdy=%b%b v=%b%b want depth %0d",
                 c, rdy32, rdy64, v32, v64, mq.size());
      end
      if (mq.size() > 0) begin
        h = mq[0];
        e = ref_imm(h.instr, h.sel);
        n_cmp++;
        if ({imm32, tag32, ill32} !== {e[31:0], h.tag, h.sel > 3'd5}) begin
          n_bad++;
          $display("FAIL rnd_x32 c=%0d got imm=%h tag=%0d ill=%b want %h %0d %b",
                   c, imm32, tag32, ill32, e[31:0], h.tag, h.sel > 3'd5);
        end
        n_cmp++;
        if ({imm64, tag64, ill64} !== {e, h.tag, h.sel > 3'd5}) begin
          n_bad++;
          $display("FAIL rnd_x64 c=%0d got imm=%h tag=%0d ill=%b want %h %0d %b",
                   c, imm64, tag64, ill64, e, h.tag, h.sel > 3'd5);
        end
      end
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_formats();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
